// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one round key per clock into a
// local register file, with a 1-cycle registered read port for the cipher core.
module aes_key_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:KEY_W-1] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             rd_en,
    input  logic [3:0]       rd_idx,
    output logic             rd_valid,
    output logic [0:KEY_W-1] rd_key,
    output logic             rd_err,
    output logic [3:0]       rk_count,
    output logic             busy,
    output logic             keys_ok
);

    localparam int unsigned NUM_RK = NUM_ROUNDS + 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [0:KEY_W-1]  rk_mem [0:NUM_RK-1];
    logic [0:KEY_W-1]  prev_key;
    logic [7:0]        rcon;

    logic              accept_c;
    logic              step_c;
    logic [0:WORD_W-1] rot_c;
    logic [0:WORD_W-1] sub_c;
    logic [0:WORD_W-1] w0_c, w1_c, w2_c, w3_c;
    logic [0:KEY_W-1]  rk_next_c;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // S-box as multiplicative inverse (x^254, zero maps to zero) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        step_c    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (key_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step_c = 1'b1;
                if (rk_count == CNT_W'(NUM_ROUNDS)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One key-expansion round from the previous round key
    always_comb begin
        rot_c     = {prev_key[104:127], prev_key[96:103]};
        sub_c     = {sbox(rot_c[0:7]), sbox(rot_c[8:15]),
                     sbox(rot_c[16:23]), sbox(rot_c[24:31])};
        w0_c      = prev_key[0:31] ^ sub_c ^ {rcon, 24'h000000};
        w1_c      = prev_key[32:63] ^ w0_c;
        w2_c      = prev_key[64:95] ^ w1_c;
        w3_c      = prev_key[96:127] ^ w2_c;
        rk_next_c = {w0_c, w1_c, w2_c, w3_c};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rk_count  <= '0;
            rcon      <= 8'h01;
            prev_key  <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            keys_ok   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            rd_key    <= '0;
        end else begin
            state     <= state_nxt;
            key_ready <= (state_nxt != EXPAND);
            busy      <= (state_nxt == EXPAND);
            keys_ok   <= (state_nxt == DONE);

            if (accept_c) begin
                prev_key <= key_in;
                rk_count <= CNT_W'(1);
                rcon     <= 8'h01;
            end else if (step_c) begin
                prev_key <= rk_next_c;
                rk_count <= rk_count + CNT_W'(1);
                rcon     <= xtime(rcon);
            end

            // Reads judge validity against the count before this edge's write
            rd_valid <= rd_en;
            if (rd_en) begin
                if (rd_idx < rk_count) begin
                    rd_key <= rk_mem[rd_idx];
                    rd_err <= 1'b0;
                end else begin
                    rd_key <= '0;
                    rd_err <= 1'b1;
                end
            end
        end
    end

    // Round-key storage, intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept_c) begin
                rk_mem[0] <= key_in;
            end else if (step_c) begin
                rk_mem[rk_count] <= rk_next_c;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl against a word-level FIPS-197 key-expansion model.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic         rd_valid;
    logic [127:0] rd_key;
    logic         rd_err;
    logic [3:0]   rk_count;
    logic         busy;
    logic         keys_ok;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk   [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_key    (rd_key),
        .rd_err    (rd_err),
        .rk_count  (rk_count),
        .busy      (busy),
        .keys_ok   (keys_ok)
    );

    // Polynomial product then reduction modulo 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [7:0]  rc [0:9];
        logic [31:0] t;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc[i / 4 - 1], 24'h0};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        model_expand(k);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 20 && !keys_ok; n++) step();
        checks++;
        if (keys_ok !== 1'b1) begin
            failures++;
            $display("FAIL wait_done keys_ok got=%b exp=1 (timeout)", keys_ok);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rd_en = 1'b0; rd_idx = '0;
        step(); step();
        checks += 7;
        if (rk_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rk_count); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (keys_ok !== 1'b0)  begin failures++; $display("FAIL reset_keys_ok got=%b exp=0", keys_ok); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        if (rd_err !== 1'b0)   begin failures++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
        if (rd_key !== '0)     begin failures++; $display("FAIL reset_rd_key got=%h exp=0", rd_key); end
        if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fips();
        accept(FIPS_KEY);
        checks += 3;
        if (rk_count !== 4'd1) begin failures++; $display("FAIL fips_e0_count got=%0d exp=1", rk_count); end
        if (busy !== 1'b1)     begin failures++; $display("FAIL fips_e0_busy got=%b exp=1", busy); end
        if (key_ready !== 1'b0) begin failures++; $display("FAIL fips_e0_ready got=%b exp=0", key_ready); end
        for (int k = 1; k <= 10; k++) begin
            step();
            checks += 3;
            if (rk_count !== 4'(k + 1)) begin failures++; $display("FAIL fips_count[%0d] got=%0d exp=%0d", k, rk_count, k + 1); end
            if (busy !== (k != 10))     begin failures++; $display("FAIL fips_busy[%0d] got=%b exp=%b", k, busy, k != 10); end
            if (keys_ok !== (k == 10))  begin failures++; $display("FAIL fips_keys_ok[%0d] got=%b exp=%b", k, keys_ok, k == 10); end
        end
        rd_en = 1'b1; rd_idx = 4'd1; step();
        checks += 2;
        if (rd_valid !== 1'b1) begin failures++; $display("FAIL fips_rk1_valid got=%b exp=1", rd_valid); end
        if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin failures++; $display("FAIL fips_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", rd_key); end
        rd_idx = 4'd10; step(); rd_en = 1'b0;
        checks++;
        if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL fips_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key); end
        step();
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL fips_rd_valid_drop got=%b exp=0", rd_valid); end
    endtask

    task automatic test_early_read();
        accept(FIPS_KEY);
        rd_en = 1'b1; rd_idx = 4'd1; step();
        checks += 2;
        if (rd_err !== 1'b1) begin failures++; $display("FAIL early_coincident_err got=%b exp=1", rd_err); end
        if (rd_key !== '0)   begin failures++; $display("FAIL early_coincident_key got=%h exp=0", rd_key); end
        rd_idx = 4'd3; step();
        checks += 2;
        if (rd_err !== 1'b1) begin failures++; $display("FAIL early_rd3_err got=%b exp=1", rd_err); end
        if (rd_key !== '0)   begin failures++; $display("FAIL early_rd3_key got=%h exp=0", rd_key); end
        rd_en = 1'b0; step();
        checks++;
        if (rk_count !== 4'd4) begin failures++; $display("FAIL early_count got=%0d exp=4", rk_count); end
        rd_en = 1'b1; rd_idx = 4'd3; step(); rd_en = 1'b0;
        checks += 2;
        if (rd_err !== 1'b0) begin failures++; $display("FAIL early_retry_err got=%b exp=0", rd_err); end
        if (rd_key !== 128'h3d80477d4716fe3e1e237e446d7a883b) begin failures++; $display("FAIL early_retry_rk3 got=%h exp=3d80477d4716fe3e1e237e446d7a883b", rd_key); end
        wait_done();
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            rd_idx = 4'(i);
            step();
            checks += 2;
            if (rd_valid !== 1'b1 || rd_err !== 1'b0) begin failures++; $display("FAIL b2b_valid[%0d] got=%b/%b exp=1/0", i, rd_valid, rd_err); end
            if (rd_key !== exp_rk[i]) begin failures++; $display("FAIL b2b_key[%0d] got=%h exp=%h", i, rd_key, exp_rk[i]); end
        end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_ignore_during_expand();
        accept(rand_key());
        for (int n = 0; n < 4; n++) begin
            key_in = rand_key(); key_valid = 1'b1;
            checks++;
            if (key_ready !== 1'b0) begin failures++; $display("FAIL ignore_ready[%0d] got=%b exp=0", n, key_ready); end
            step();
        end
        key_valid = 1'b0;
        wait_done();
        test_back_to_back();
        accept('0);
        wait_done();
        rd_en = 1'b1; rd_idx = 4'd10; step(); rd_en = 1'b0;
        checks += 2;
        if (rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin failures++; $display("FAIL zero_rk10 got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e", rd_key); end
        if (rd_key !== exp_rk[10]) begin failures++; $display("FAIL zero_rk10_model got=%h exp=%h", rd_key, exp_rk[10]); end
    endtask

    task automatic test_reset_mid();
        accept(rand_key());
        for (int n = 0; n < 4; n++) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        checks += 4;
        if (rk_count !== 4'd0)  begin failures++; $display("FAIL midrst_count got=%0d exp=0", rk_count); end
        if (keys_ok !== 1'b0)   begin failures++; $display("FAIL midrst_keys_ok got=%b exp=0", keys_ok); end
        if (key_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", key_ready); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_idx = 4'($urandom_range(0, 10));
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_err !== 1'b1) begin failures++; $display("FAIL midrst_read[%0d] got=%b/%b exp=1/1", i, rd_valid, rd_err); end
        end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_out_of_range();
        accept(rand_key());
        wait_done();
        rd_en = 1'b1;
        for (int i = 11; i < 16; i++) begin
            rd_idx = 4'(i);
            step();
            checks += 2;
            if (rd_err !== 1'b1) begin failures++; $display("FAIL oob_err[%0d] got=%b exp=1", i, rd_err); end
            if (rd_key !== '0)   begin failures++; $display("FAIL oob_key[%0d] got=%h exp=0", i, rd_key); end
        end
        rd_en = 1'b0;
        test_back_to_back();
    endtask

    task automatic test_accept_read();
        logic [127:0] old0;
        logic [127:0] k;
        old0 = exp_rk[0];
        k = rand_key();
        rd_en = 1'b1; rd_idx = 4'd0;
        accept(k);
        checks += 2;
        if (rd_key !== old0 || rd_err !== 1'b0) begin failures++; $display("FAIL accept_read_old got=%h exp=%h", rd_key, old0); end
        if (rk_count !== 4'd1) begin failures++; $display("FAIL accept_read_count got=%0d exp=1", rk_count); end
        step(); rd_en = 1'b0;
        checks++;
        if (rd_key !== k) begin failures++; $display("FAIL accept_read_new got=%h exp=%h", rd_key, k); end
        wait_done();
    endtask

    // Random reads overlapping expansion, judged by a cycle-count model of availability
    task automatic test_overlap_random();
        int cnt;
        int pre;
        int idx;
        logic exp_err;
        accept(rand_key());
        cnt = 1;
        rd_en = 1'b1;
        for (int n = 0; n < 14; n++) begin
            idx = $urandom_range(0, 15);
            rd_idx = 4'(idx);
            pre = cnt;
            step();
            cnt = (pre < 11) ? pre + 1 : 11;
            exp_err = (idx >= pre);
            checks += 3;
            if (rk_count !== 4'(cnt)) begin failures++; $display("FAIL overlap_count[%0d] got=%0d exp=%0d", n, rk_count, cnt); end
            if (rd_err !== exp_err)   begin failures++; $display("FAIL overlap_err[%0d] idx=%0d got=%b exp=%b", n, idx, rd_err, exp_err); end
            if (rd_key !== (exp_err ? 128'h0 : exp_rk[idx])) begin failures++; $display("FAIL overlap_key[%0d] idx=%0d got=%h", n, idx, rd_key); end
        end
        rd_en = 1'b0;
        step();
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_fips();
        test_early_read();
        test_ignore_during_expand();
        test_reset_mid();
        test_out_of_range();
        test_accept_read();
        for (int r = 0; r < 3; r++) test_overlap_random();
        for (int r = 0; r < 2; r++) begin
            accept(rand_key());
            wait_done();
            test_back_to_back();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
